fifo_uart_tx: RTL and testbench

UART transmitter that drains the FIFO: it pops bytes from the FIFO read port (`empty`/`rd`/`r_data`) and sends each one as an asynchronous serial frame (start bit, LSB-first data, stop bits) on `tx`. It sits on the read side of the FIFO, with the producer writing into the FIFO. Back-to-back bytes are streamed with no software involvement.

---
 rtl/uart_pkg.sv | 19 +
 rtl/fifo_uart_tx_baud_counter.sv | 29 ++
 rtl/fifo_uart_tx.sv | 102 ++++++++++
 tb/tb_fifo_uart_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor
// and the bit-index width helper used by the transmitter and receiver.
package uart_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

   // 50 MHz system clock, 9600 baud
   localparam int BAUD_DIV_DEF = 5208;

   function automatic int idx_w(input int b);
      return (b > 1) ? $clog2(b) : 1;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Free-running bit-period counter, 0..BAUD_DIV-1, with synchronous clear.
// tick marks the last cycle of each bit period.
module baud_counter #(
   parameter int BAUD_DIV = 5208
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO read port, one frame per popped
// byte, streaming back-to-back frames with a single idle cycle between.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int B        = 8,
   parameter int BAUD_DIV = BAUD_DIV_DEF,
   parameter int SB       = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tx_en,
   input  logic         empty,
   input  logic [B-1:0] r_data,
   output logic         rd,
   output logic         tx,
   output logic         tx_busy,
   output logic         tx_done_tick
);

   localparam int IW = idx_w(B);
   localparam logic [IW-1:0] LAST_IDX = IW'(B - 1);
   localparam logic STOP_LAST = (SB == 2);

   state_t        state_q;
   logic [B-1:0]  sh_q;
   logic [B-1:0]  sh_nx;
   logic [IW-1:0] idx_q;
   logic          stop_q;
   logic          tx_q;
   logic          start;
   logic          tick;

   // Pop is held off while reset is asserted so no byte is lost then
   assign start = reset_n && (state_q == ST_IDLE) && tx_en && !empty;
   assign sh_nx = sh_q >> 1;

   assign rd           = start;
   assign tx           = tx_q;
   assign tx_busy      = (state_q != ST_IDLE);
   assign tx_done_tick = (state_q == ST_STOP) && tick
                         && (stop_q == STOP_LAST);

   baud_counter #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (start),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sh_q    <= r_data;
                  idx_q   <= '0;
                  stop_q  <= 1'b0;
                  tx_q    <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  tx_q    <= sh_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (idx_q == LAST_IDX) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     sh_q  <= sh_nx;
                     tx_q  <= sh_nx[0];
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: begin
               if (tick) begin
                  if (stop_q == STOP_LAST) begin
                     state_q <= ST_IDLE;
                  end else begin
                     stop_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: two instances (1 and 2 stop bits),
// each fed by a small FIFO model, with serial frames decoded from tx.
module tb_fifo_uart_tx;

   localparam int DIV = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       tx_en1, empty1, rd1, tx1, busy1, done1;
   logic       tx_en2, empty2, rd2, tx2, busy2, done2;
   logic [7:0] rdata1, rdata2;
   logic [7:0] mem1[16];
   logic [7:0] mem2[16];
   int         wp1, rp1, wp2, rp2;
   int         sel;
   logic       rd_m, tx_m, done_m, busy_m;
   logic [7:0] exp_q[$];
   int         n_cmp, n_bad;

   assign empty1 = (wp1 == rp1);
   assign empty2 = (wp2 == rp2);
   assign rdata1 = mem1[rp1[3:0]];
   assign rdata2 = mem2[rp2[3:0]];
   assign rd_m   = (sel == 0) ? rd1 : rd2;
   assign tx_m   = (sel == 0) ? tx1 : tx2;
   assign done_m = (sel == 0) ? done1 : done2;
   assign busy_m = (sel == 0) ? busy1 : busy2;

   always @(posedge clk) begin
      if (rd1) rp1 <= rp1 + 1;
      if (rd2) rp2 <= rp2 + 1;
   end

   fifo_uart_tx #(.B(8), .BAUD_DIV(DIV), .SB(1)) dut (
      .clk(clk), .reset_n(rst_n), .tx_en(tx_en1), .empty(empty1),
      .r_data(rdata1), .rd(rd1), .tx(tx1), .tx_busy(busy1),
      .tx_done_tick(done1)
   );

   fifo_uart_tx #(.B(8), .BAUD_DIV(DIV), .SB(2)) dut2 (
      .clk(clk), .reset_n(rst_n), .tx_en(tx_en2), .empty(empty2),
      .r_data(rdata2), .rd(rd2), .tx(tx2), .tx_busy(busy2),
      .tx_done_tick(done2)
   );

   task automatic push(input logic [7:0] b);
      if (sel == 0) begin
         mem1[wp1[3:0]] = b;
         wp1++;
      end else begin
         mem2[wp2[3:0]] = b;
         wp2++;
      end
      exp_q.push_back(b);
   endtask

   task automatic pop_exp(output logic [7:0] e);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
   endtask

   task automatic wait_rd(input int budget, output int cyc);
      cyc = 0;
      #1;
      while (rd_m !== 1'b1 && cyc >= 0) begin
         @(negedge clk); #1;
         cyc++;
         if (cyc > budget) cyc = -1;
      end
   endtask

   task automatic capture(input int n, output logic [7:0] d,
                          output logic [127:0] w, output int done_at,
                          output int n_done, output int n_rd,
                          output int n_busy);
      w = '1;
      w[0] = tx_m;
      done_at = -1;
      n_done = 0;
      n_rd = 0;
      n_busy = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk); #1;
         w[i] = tx_m;
         if (done_m) begin n_done++; done_at = i; end
         if (rd_m) n_rd++;
         if (busy_m) n_busy++;
      end
      for (int k = 0; k < 8; k++) d[k] = w[DIV*(k+1)+2];
   endtask

   function automatic logic [127:0] wave(input logic [7:0] b);
      logic [127:0] w;
      w = '1;
      for (int i = 1; i <= DIV; i++) w[i] = 1'b0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < DIV; j++) w[DIV*(k+1)+1+j] = b[k];
      return w;
   endfunction

   task automatic test_reset();
      logic [7:0] d, e;
      logic [127:0] w;
      int da, nd, nr, nb;
      sel = 0;
      rst_n = 1'b0;
      tx_en1 = 1'b1;
      push(8'h5A);
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (tx1 !== 1'b1) begin
         n_bad++; $display("FAIL reset_tx got %b want 1", tx1);
      end
      n_cmp++;
      if (rd1 !== 1'b0) begin
         n_bad++; $display("FAIL reset_rd got %b want 0", rd1);
      end
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy_done got %b%b want 00", busy1, done1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (rd1 !== 1'b1) begin
         n_bad++; $display("FAIL first_rd got %b want 1", rd1);
      end
      capture(40, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e) begin
         n_bad++; $display("FAIL reset_byte got %h want %h", d, e);
      end
   endtask

   task automatic test_single();
      logic [7:0] d, e;
      logic [127:0] w;
      int c, da, nd, nr, nb;
      push(8'hA5);
      wait_rd(10, c);
      n_cmp++;
      if (c !== 1) begin
         n_bad++; $display("FAIL single_rd_wait got %0d want 1", c);
      end
      capture(40, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e) begin
         n_bad++; $display("FAIL single_byte got %h want %h", d, e);
      end
      n_cmp++;
      if (w !== wave(8'hA5)) begin
         n_bad++;
         $display("FAIL single_wave got %h want %h", w, wave(8'hA5));
      end
      n_cmp++;
      if (da !== 40 || nd !== 1) begin
         n_bad++;
         $display("FAIL single_done got at %0d x%0d want at 40 x1", da, nd);
      end
      n_cmp++;
      if (nr !== 0 || nb !== 40) begin
         n_bad++;
         $display("FAIL single_rd_busy got rd %0d busy %0d want 0 40",
                  nr, nb);
      end
      n_cmp++;
      if (empty1 !== 1'b1) begin
         n_bad++; $display("FAIL single_empty got %b want 1", empty1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d, e;
      logic [127:0] w;
      int c, da, nd, nr, nb;
      push(8'h00);
      push(8'hFF);
      wait_rd(10, c);
      capture(40, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e || w !== wave(8'h00)) begin
         n_bad++; $display("FAIL b2b_first got %h want %h", d, e);
      end
      wait_rd(10, c);
      n_cmp++;
      if (40 + c !== 41) begin
         n_bad++; $display("FAIL b2b_period got %0d want 41", 40 + c);
      end
      n_cmp++;
      if (tx1 !== 1'b1) begin
         n_bad++; $display("FAIL b2b_idle_tx got %b want 1", tx1);
      end
      capture(40, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e || w !== wave(8'hFF)) begin
         n_bad++; $display("FAIL b2b_second got %h want %h", d, e);
      end
   endtask

   task automatic test_tx_en();
      logic [7:0] d, e;
      logic [127:0] w;
      int c, da, nd, nr, nb, quiet;
      push(8'h3C);
      push(8'h77);
      wait_rd(10, c);
      fork
         capture(40, d, w, da, nd, nr, nb);
         begin
            repeat (13) @(negedge clk);
            #2;
            tx_en1 = 1'b0;
         end
      join
      pop_exp(e);
      n_cmp++;
      if (d !== e || w !== wave(8'h3C)) begin
         n_bad++; $display("FAIL txen_frame got %h want %h", d, e);
      end
      quiet = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (rd1) quiet++;
      end
      n_cmp++;
      if (quiet !== 0 || empty1 !== 1'b0) begin
         n_bad++;
         $display("FAIL txen_hold got rd %0d empty %b want 0 0",
                  quiet, empty1);
      end
      tx_en1 = 1'b1;
      wait_rd(10, c);
      n_cmp++;
      if (c !== 0) begin
         n_bad++; $display("FAIL txen_resume got %0d want 0", c);
      end
      capture(40, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e || w[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL txen_next got %h start %b want %h 0", d, w[1], e);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d, e, lost;
      logic [127:0] w;
      int c, da, nd, nr, nb, extra;
      push(8'h55);
      push(8'h66);
      wait_rd(10, c);
      repeat (18) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_abort got tx %b busy %b want 1 0", tx1, busy1);
      end
      pop_exp(lost);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      wait_rd(10, c);
      capture(40, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e || w !== wave(8'h66)) begin
         n_bad++; $display("FAIL midrst_next got %h want %h", d, e);
      end
      extra = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (rd1) extra++;
      end
      n_cmp++;
      if (extra !== 0 || empty1 !== 1'b1 || lost !== 8'h55) begin
         n_bad++;
         $display("FAIL midrst_no_resend got rd %0d empty %b want 0 1",
                  extra, empty1);
      end
   endtask

   task automatic test_sb2();
      logic [7:0] d, e;
      logic [127:0] w;
      int c, da, nd, nr, nb;
      sel = 1;
      push(8'h81);
      push(8'h42);
      tx_en2 = 1'b1;
      wait_rd(10, c);
      capture(44, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e || w !== wave(8'h81)) begin
         n_bad++; $display("FAIL sb2_frame got %h want %h", d, e);
      end
      n_cmp++;
      if (da !== 44 || nd !== 1) begin
         n_bad++;
         $display("FAIL sb2_done got at %0d x%0d want at 44 x1", da, nd);
      end
      wait_rd(10, c);
      n_cmp++;
      if (44 + c !== 45) begin
         n_bad++; $display("FAIL sb2_period got %0d want 45", 44 + c);
      end
      capture(44, d, w, da, nd, nr, nb);
      pop_exp(e);
      n_cmp++;
      if (d !== e || w !== wave(8'h42)) begin
         n_bad++; $display("FAIL sb2_second got %h want %h", d, e);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      sel = 0;
      rst_n = 1'b0;
      tx_en1 = 1'b0;
      tx_en2 = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_tx_en();
      test_reset_mid();
      test_sb2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
